// File: rtl/cpu_pkg.sv
// Shared fetch-PC types: PC-generator state, redirect priority encoding and the boot vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  // Numeric order matters: a larger code always outranks a smaller one.
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_BR   = 2'd1,
    PRI_ERET = 2'd2,
    PRI_EXC  = 2'd3
  } redir_pri_e;

  localparam logic [31:0] RESET_PC_DFLT = 32'hBFC0_0000;

endpackage

// File: rtl/redirect_sel.sv
// Combinational exc > eret > br priority encoder returning {priority, target}.
// Zero latency, no state, no flow control.
module redirect_sel
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_exc_valid,
  input  logic [WIDTH-1:0] i_exc_target,
  input  logic             i_eret_valid,
  input  logic [WIDTH-1:0] i_eret_target,
  input  logic             i_br_valid,
  input  logic [WIDTH-1:0] i_br_target,
  output redir_pri_e       o_pri,
  output logic [WIDTH-1:0] o_target
);

  always_comb begin
    o_pri    = PRI_NONE;
    o_target = '0;
    if (i_exc_valid) begin
      o_pri    = PRI_EXC;
      o_target = i_exc_target;
    end else if (i_eret_valid) begin
      o_pri    = PRI_ERET;
      o_target = i_eret_target;
    end else if (i_br_valid) begin
      o_pri    = PRI_BR;
      o_target = i_br_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: one-cycle redirect/step latency; fetch_ready=0 holds the PC,
// stall holds it and buffers the best redirect until release.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DFLT),
  parameter int               FETCH_BYTES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_target,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] eret_target,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             pc_misaligned,
  output logic             redirect_pending
);

  localparam int ALIGN_BITS = $clog2(FETCH_BYTES);

  pc_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt;
  redir_pri_e       r_buf_pri, w_buf_pri_nxt;
  logic [WIDTH-1:0] r_buf_tgt, w_buf_tgt_nxt;

  redir_pri_e       w_live_pri, w_mrg_slot, w_mrg_pri;
  logic [WIDTH-1:0] w_live_tgt, w_mrg_tgt;
  logic             w_buf_wins;

  redirect_sel #(.WIDTH(WIDTH)) u_live_sel (
    .i_exc_valid  (exc_valid),
    .i_exc_target (exc_target),
    .i_eret_valid (eret_valid),
    .i_eret_target(eret_target),
    .i_br_valid   (br_valid),
    .i_br_target  (br_target),
    .o_pri        (w_live_pri),
    .o_target     (w_live_tgt)
  );

  // Buffer sits in the top slot only when it outranks or ties the live pick.
  assign w_buf_wins = (r_buf_pri != PRI_NONE) && (r_buf_pri >= w_live_pri);

  redirect_sel #(.WIDTH(WIDTH)) u_merge_sel (
    .i_exc_valid  (w_buf_wins),
    .i_exc_target (r_buf_tgt),
    .i_eret_valid (w_live_pri != PRI_NONE),
    .i_eret_target(w_live_tgt),
    .i_br_valid   (1'b0),
    .i_br_target  ({WIDTH{1'b0}}),
    .o_pri        (w_mrg_slot),
    .o_target     (w_mrg_tgt)
  );

  assign w_mrg_pri = (w_mrg_slot == PRI_EXC) ? r_buf_pri : w_live_pri;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_pri_nxt = r_buf_pri;
    w_buf_tgt_nxt = r_buf_tgt;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (w_live_pri != PRI_NONE) w_pc_nxt = w_live_tgt;
          else if (fetch_ready)       w_pc_nxt = r_pc + WIDTH'(FETCH_BYTES);
        end else if (w_live_pri != PRI_NONE) begin
          w_buf_pri_nxt = w_live_pri;
          w_buf_tgt_nxt = w_live_tgt;
          w_state_nxt   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (stall) begin
          w_buf_pri_nxt = w_mrg_pri;
          w_buf_tgt_nxt = w_mrg_tgt;
        end else begin
          w_pc_nxt      = w_mrg_tgt;
          w_buf_pri_nxt = PRI_NONE;
          w_buf_tgt_nxt = '0;
          w_state_nxt   = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_buf_pri <= PRI_NONE;
      r_buf_tgt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_buf_pri <= w_buf_pri_nxt;
      r_buf_tgt <= w_buf_tgt_nxt;
    end
  end

  assign pc               = r_pc;
  assign pc_valid         = (r_state != ST_BOOT);
  assign pc_misaligned    = |r_pc[ALIGN_BITS-1:0];
  assign redirect_pending = (r_state == ST_PEND);

endmodule
